// File: rtl/prog_loader_if.sv
// Byte-stream input and instr_mem write-port bundle for prog_loader.
// The slave modport is the loader; the master modport is whatever feeds the stream and watches the writes.
interface prog_loader_if #(
   parameter int ADDRESS_REAL_WIDTH = 12,
   parameter int DATA_WIDTH         = 8
);
   logic                          in_valid;
   logic [DATA_WIDTH-1:0]         in_data;
   logic                          in_ready;
   logic                          wr_en;
   logic [ADDRESS_REAL_WIDTH-1:0] wr_addr;
   logic [31:0]                   wr_data;

   modport master (
      output in_valid, in_data,
      input  in_ready, wr_en, wr_addr, wr_data
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/prog_loader.sv
// Instruction-memory loader: length-prefixed little-endian byte stream -> 32-bit word writes.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module prog_loader #(
   parameter int ADDRESS_REAL_WIDTH = 12,
   parameter int DATA_WIDTH         = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   prog_loader_if.slave bus,
   output logic         cpu_hold,
   output logic         done,
   output logic         err
);
   localparam int          AW       = ADDRESS_REAL_WIDTH;
   localparam logic [32:0] CAPACITY = 33'(1) << AW;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_LOAD,
      S_FLUSH,
      S_DONE,
      S_ERR
`ifdef LOADER_CHECKSUM_EN
      , S_CSUM
`endif
   } state_t;

`ifdef LOADER_CHECKSUM_EN
   localparam state_t S_END = S_CSUM;
`else
   localparam state_t S_END = S_DONE;
`endif

   state_t      state, state_nxt;
   logic [1:0]  hdr_cnt;
   logic [31:0] len;
   logic [AW:0] cnt;
   logic [31:0] word_buf;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]  csum;
`endif

   logic        accept;
   logic        start_ok;
   logic [31:0] len_full;
   logic [AW:0] cnt_inc;
   logic [1:0]  lane;
   logic        last_byte;
   logic [31:0] word_nxt;

   assign accept    = bus.in_valid && bus.in_ready;
   assign start_ok  = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
   assign len_full  = {bus.in_data, len[23:0]};
   assign cnt_inc   = cnt + (AW+1)'(1);
   assign lane      = cnt[1:0];
   assign last_byte = (cnt_inc == len[AW:0]);

   always_comb begin
      word_nxt = word_buf;
      word_nxt[lane*DATA_WIDTH +: DATA_WIDTH] = bus.in_data;
   end

   // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt    = state;
      bus.in_ready = 1'b0;
      done         = (state == S_DONE);
      err          = (state == S_ERR);
      cpu_hold     = (state != S_DONE);
      case (state)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) state_nxt = S_HDR;
         end
         S_HDR: begin
            bus.in_ready = 1'b1;
            if (accept && hdr_cnt == 2'd3) begin
               if ({1'b0, len_full} > CAPACITY) state_nxt = S_ERR;
               else if (len_full == 32'd0)      state_nxt = S_END;
               else                             state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            bus.in_ready = 1'b1;
            if (accept && last_byte) state_nxt = (lane == 2'd3) ? S_END : S_FLUSH;
         end
         S_FLUSH: state_nxt = S_END;
`ifdef LOADER_CHECKSUM_EN
         S_CSUM: begin
            bus.in_ready = 1'b1;
            if (accept) state_nxt = (bus.in_data == csum) ? S_DONE : S_ERR;
         end
`endif
         default: state_nxt = S_IDLE;
      endcase
   end

   // Datapath: header capture, word assembly and the registered write strobe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hdr_cnt     <= '0;
         len         <= '0;
         cnt         <= '0;
         word_buf    <= '0;
         bus.wr_en   <= 1'b0;
         bus.wr_addr <= '0;
         bus.wr_data <= '0;
`ifdef LOADER_CHECKSUM_EN
         csum        <= '0;
`endif
      end else begin
         bus.wr_en <= 1'b0;
         if (start_ok) begin
            hdr_cnt  <= '0;
            len      <= '0;
            cnt      <= '0;
            word_buf <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
         end
         if (state == S_HDR && accept) begin
            len[hdr_cnt*DATA_WIDTH +: DATA_WIDTH] <= bus.in_data;
            hdr_cnt <= hdr_cnt + 2'd1;
         end
         if (state == S_LOAD && accept) begin
            cnt <= cnt_inc;
`ifdef LOADER_CHECKSUM_EN
            csum <= csum ^ bus.in_data;
`endif
            // A partial final word goes out with its unused upper lanes still zero.
            if (lane == 2'd3 || last_byte) begin
               bus.wr_en   <= 1'b1;
               bus.wr_addr <= {cnt[AW-1:2], 2'b00};
               bus.wr_data <= word_nxt;
               word_buf    <= '0;
            end else begin
               word_buf    <= word_nxt;
            end
         end
      end
   end
endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: byte-index model predicts every write and its cycle,
// plus literal expectations for the documented example streams.
module tb_prog_loader;
   localparam int AW  = 12;
   localparam int CAP = 1 << AW;

   logic clk      = 1'b0;
   logic rst      = 1'b1;
   logic start    = 1'b0;
   logic cpu_hold;
   logic done;
   logic err;

   prog_loader_if #(.ADDRESS_REAL_WIDTH(AW)) bus ();

   prog_loader #(.ADDRESS_REAL_WIDTH(AW)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .bus      (bus.slave),
      .cpu_hold (cpu_hold),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state for the current load.
   byte unsigned pay[$];
   int           exp_len  = 0;
   bit           len_ok   = 1'b0;
   int           acc_k    = 0;
   int           wr_count = 0;
   logic [31:0]  log_addr[$];
   logic [31:0]  log_data[$];
   bit           pend     = 1'b0;
   logic [31:0]  paddr    = '0;
   logic [31:0]  pdata    = '0;
   int           last_cycles;
   int           last_size;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] log_at(input bit is_addr, input int i);
      if (i < 0 || i >= log_addr.size()) return 32'hxxxx_xxxx;
      return is_addr ? log_addr[i] : log_data[i];
   endfunction

   // Compare process: every payload byte that closes a word must produce exactly one write next cycle.
   always @(negedge clk) begin
      int          p;
      int          base;
      logic [31:0] w;
      if (!rst) begin
         pend = 1'b0;
         check("rst_wr_en",    bus.wr_en,    64'd0);
         check("rst_wr_addr",  bus.wr_addr,  64'd0);
         check("rst_wr_data",  bus.wr_data,  64'd0);
         check("rst_in_ready", bus.in_ready, 64'd0);
         check("rst_done",     done,         64'd0);
         check("rst_err",      err,          64'd0);
         check("rst_cpu_hold", cpu_hold,     64'd1);
      end else begin
         if (pend) begin
            check("wr_en",   bus.wr_en,   64'd1);
            check("wr_addr", bus.wr_addr, paddr);
            check("wr_data", bus.wr_data, pdata);
         end else begin
            check("wr_quiet", bus.wr_en, 64'd0);
         end
         if (bus.wr_en) begin
            wr_count++;
            log_addr.push_back(32'(bus.wr_addr));
            log_data.push_back(bus.wr_data);
         end
         pend = 1'b0;
         if (bus.in_valid && bus.in_ready) begin
            p = acc_k - 4;
            acc_k++;
            if (len_ok && p >= 0 && p < exp_len && (p % 4 == 3 || p == exp_len - 1)) begin
               base = p - (p % 4);
               w    = '0;
               for (int j = 0; j < 4; j++)
                  if (base + j < exp_len) w |= 32'(pay[base + j]) << (8 * j);
               pend  = 1'b1;
               paddr = 32'(base);
               pdata = w;
            end
         end
      end
   end

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Drive bytes one per handshake; noisy mode inserts valid gaps and stray start pulses.
   task automatic send(input byte unsigned s[$], input bit noisy, output int cycles);
      int guard;
      bit got;
      cycles = 0;
      foreach (s[i]) begin
         if (noisy) begin
            while ($urandom_range(0, 2) == 0) begin
               bus.in_valid = 1'b0;
               start = ($urandom_range(0, 7) == 0);
               @(posedge clk); #1;
               cycles++;
            end
         end
         bus.in_valid = 1'b1;
         bus.in_data  = s[i];
         guard = 0;
         do begin
            start = noisy && ($urandom_range(0, 7) == 0);
            @(negedge clk);
            got = bus.in_ready;
            @(posedge clk); #1;
            cycles++;
            guard++;
         end while (!got && guard < 100);
         if (!got) begin
            check("in_ready_timeout", got, 64'd1);
            break;
         end
      end
      bus.in_valid = 1'b0;
      start = 1'b0;
   endtask

   function automatic void model_begin(input int len);
      exp_len  = len;
      len_ok   = (len <= CAP);
      acc_k    = 0;
      wr_count = 0;
      log_addr.delete();
      log_data.delete();
   endfunction

   task automatic do_load(input int len, input bit noisy, input bit bad_csum);
      byte unsigned s[$];
      byte unsigned x;
      bit           exp_done;
      model_begin(len);
      pulse_start();
      for (int j = 0; j < 4; j++) s.push_back(8'(len >> (8 * j)));
      x = 8'h00;
      if (len_ok) begin
         for (int i = 0; i < len; i++) begin
            s.push_back(pay[i]);
            x ^= pay[i];
         end
      end
`ifdef LOADER_CHECKSUM_EN
      if (len_ok) s.push_back(bad_csum ? (x ^ 8'h01) : x);
      exp_done = len_ok && !bad_csum;
`else
      exp_done = len_ok;
`endif
      last_size = s.size();
      send(s, noisy, last_cycles);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("end_done",     done,         64'(exp_done));
      check("end_err",      err,          64'(!exp_done));
      check("end_cpu_hold", cpu_hold,     64'(!exp_done));
      check("end_in_ready", bus.in_ready, 64'd0);
      check("end_writes",   wr_count,     64'(len_ok ? (len + 3) / 4 : 0));
      @(posedge clk); #1;
   endtask

   task automatic random_pay(input int n);
      pay.delete();
      for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
   endtask

   initial begin
      byte unsigned s[$];
      int len;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      #2 rst = 1'b0;
      repeat (3) @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      // Stream bytes in IDLE must be ignored.
      bus.in_valid = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("idle_in_ready", bus.in_ready, 64'd0);
      check("idle_cpu_hold", cpu_hold,     64'd1);
      check("idle_writes",   wr_count,     64'd0);
      bus.in_valid = 1'b0;
      @(posedge clk); #1;

      // Two full words.
      pay = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
      do_load(8, 1'b0, 1'b0);
      check("ex1_addr0", log_at(1, 0), 64'h000);
      check("ex1_data0", log_at(0, 0), 64'h00A0_0513);
      check("ex1_addr1", log_at(1, 1), 64'h004);
      check("ex1_data1", log_at(0, 1), 64'h0000_006F);

      // Partial last word goes out through FLUSH.
      pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      do_load(5, 1'b0, 1'b0);
      check("ex2_data0", log_at(0, 0), 64'h4433_2211);
      check("ex2_addr1", log_at(1, 1), 64'h004);
      check("ex2_data1", log_at(0, 1), 64'h0000_0055);

      // One byte over capacity, then recovery from ERR.
      do_load(CAP + 1, 1'b0, 1'b0);
      check("over_err", err, 64'd1);
      pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      do_load(4, 1'b0, 1'b0);
      check("recover_data", log_at(0, 0), 64'hEFBE_ADDE);

      // Empty payload.
      do_load(0, 1'b0, 1'b0);

      // Full capacity at full rate.
      random_pay(CAP);
      do_load(CAP, 1'b0, 1'b0);
      check("cap_last_addr", log_at(1, log_addr.size() - 1), 64'(CAP - 4));
      check("cap_no_bubble", last_cycles, 64'(last_size));

      // Reset in the middle of a payload.
      random_pay(16);
      model_begin(16);
      pulse_start();
      s = '{8'd16, 8'd0, 8'd0, 8'd0};
      for (int i = 0; i < 6; i++) s.push_back(pay[i]);
      send(s, 1'b0, last_cycles);
      rst = 1'b0;
      repeat (3) @(posedge clk); #1;
      rst = 1'b1;
      bus.in_valid = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("midrst_writes",   wr_count,     64'd1);
      check("midrst_in_ready", bus.in_ready, 64'd0);
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      random_pay(12);
      do_load(12, 1'b0, 1'b0);
      check("midrst_restart", log_at(1, 0), 64'h000);

`ifdef LOADER_CHECKSUM_EN
      pay = '{8'h01, 8'h02, 8'h03, 8'h04};
      do_load(4, 1'b0, 1'b0);
      check("csum_ok_data", log_at(0, 0), 64'h0403_0201);
      do_load(4, 1'b0, 1'b1);
      check("csum_bad_data", log_at(0, 0), 64'h0403_0201);
`endif

      // Randomized loads with gaps and stray start pulses.
      for (int t = 0; t < 30; t++) begin
         len = ($urandom_range(0, 7) == 0) ? CAP + int'($urandom_range(1, 300))
                                           : int'($urandom_range(0, 40));
         random_pay(len <= CAP ? len : 0);
`ifdef LOADER_CHECKSUM_EN
         do_load(len, 1'b1, ($urandom_range(0, 3) == 0));
`else
         do_load(len, 1'b1, 1'b0);
`endif
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
